// File: rtl/constants_pkg.sv
// Architecture-wide constants shared by the pipeline stages.
package constants_pkg;
  localparam int ARCH_LEN = 32;
  localparam int INST_W   = 32;
endpackage

// File: rtl/structure_pkg.sv
// Shared pipeline structures: fetch-queue entry and address helper.
package structure_pkg;
  import constants_pkg::*;

  typedef struct packed {
    logic [ARCH_LEN-1:0] pc;
    logic [INST_W-1:0]   data;
    logic                filled;
  } fetch_entry_t;

  // Force an address onto a word boundary.
  function automatic logic [ARCH_LEN-1:0] word_align(input logic [ARCH_LEN-1:0] a);
    return {a[ARCH_LEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: circular buffer of fetch entries. Entries are allocated
// (unfilled) when a request is accepted, filled in order by responses and
// popped in order by decode. Flush drops every entry at once.
module fetch_queue
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                alloc,
  input  logic [ARCH_LEN-1:0] alloc_pc,
  input  logic                fill,
  input  logic [INST_W-1:0]   fill_data,
  input  logic                pop,
  output fetch_entry_t        head,
  output logic [CNT_W-1:0]    occ
);

  fetch_entry_t     q [DEPTH];
  logic [PTR_W-1:0] hd_ptr, tl_ptr, fl_ptr;

  assign head = q[hd_ptr];

  // Pointer/occupancy bookkeeping and entry writes. Alloc, fill and pop may
  // all happen together; alloc and fill never target the same slot because
  // the fill pointer always trails the tail over allocated entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      hd_ptr <= '0;
      tl_ptr <= '0;
      fl_ptr <= '0;
      occ    <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else if (flush) begin
      // Stale slot contents stay put: occ == 0 hides them and a later
      // allocation rewrites filled before the slot is visible again.
      hd_ptr <= '0;
      tl_ptr <= '0;
      fl_ptr <= '0;
      occ    <= '0;
    end else begin
      if (alloc) begin
        q[tl_ptr] <= '{pc: alloc_pc, data: '0, filled: 1'b0};
        tl_ptr    <= tl_ptr + PTR_W'(1);
      end
      if (fill) begin
        q[fl_ptr].data   <= fill_data;
        q[fl_ptr].filled <= 1'b1;
        fl_ptr           <= fl_ptr + PTR_W'(1);
      end
      if (pop) hd_ptr <= hd_ptr + PTR_W'(1);
      occ <= occ + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues sequential imem reads, buffers returned
// instructions in fetch_queue and hands them to decode in order. A taken
// branch from execute restarts fetch at the target and squashes all younger
// work, including responses still in flight (counted off via drop_cnt).
// Optional: define FETCH_REDIRECT_CNT_EN for a 32-bit redirect counter port.
module fetch_stage
  import constants_pkg::*;
  import structure_pkg::*;
#(
  parameter int                  QUEUE_DEPTH = 4,
  parameter logic [ARCH_LEN-1:0] RESET_PC    = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                br_tk_in,
  input  logic [ARCH_LEN-1:0] pc_br_tk_in,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [ARCH_LEN-1:0] imem_req_addr,
  input  logic                imem_resp_valid,
  input  logic [INST_W-1:0]   imem_resp_data,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [INST_W-1:0]   inst_data,
  output logic [ARCH_LEN-1:0] inst_pc
`ifdef FETCH_REDIRECT_CNT_EN
  ,
  output logic [31:0]         redirect_cnt
`endif
);

  localparam int               CNT_W   = $clog2(QUEUE_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(QUEUE_DEPTH);

  logic [ARCH_LEN-1:0] fpc;
  logic [CNT_W-1:0]    occ, inflight, drop_cnt;
  fetch_entry_t        head;
  logic                req_acc, pop, fill;

  // Head is hidden in the redirect cycle so decode never takes a squashed op.
  assign inst_valid = head.filled & (occ != '0) & ~br_tk_in;
  assign inst_data  = head.data;
  assign inst_pc    = head.pc;
  assign pop        = inst_valid & inst_ready;

  // A slot freed by this cycle's pop may be reused by this cycle's request.
  assign imem_req_valid = ~rst & ~br_tk_in & ((occ < DEPTH_C) | pop);
  assign imem_req_addr  = fpc;
  assign req_acc        = imem_req_valid & imem_req_ready;

  // Responses owed to squashed requests are consumed without filling.
  assign fill = imem_resp_valid & (drop_cnt == '0) & ~br_tk_in;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (br_tk_in),
    .alloc     (req_acc),
    .alloc_pc  (fpc),
    .fill      (fill),
    .fill_data (imem_resp_data),
    .pop       (pop),
    .head      (head),
    .occ       (occ)
  );

  // Fetch PC: redirect beats sequential increment.
  always_ff @(posedge clk) begin
    if (rst)           fpc <= RESET_PC;
    else if (br_tk_in) fpc <= word_align(pc_br_tk_in);
    else if (req_acc)  fpc <= fpc + ARCH_LEN'(4);
  end

  // Outstanding requests and the share of them to discard. drop_cnt is
  // reloaded from inflight (not from unfilled entries) so a redirect during
  // an earlier drop window still covers the older squashed requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
      drop_cnt <= '0;
    end else begin
      inflight <= inflight + CNT_W'(req_acc) - CNT_W'(imem_resp_valid);
      if (br_tk_in)
        drop_cnt <= inflight - CNT_W'(imem_resp_valid);
      else if (imem_resp_valid && drop_cnt != '0)
        drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

`ifdef FETCH_REDIRECT_CNT_EN
  // Count redirect cycles; wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst)           redirect_cnt <= '0;
    else if (br_tk_in) redirect_cnt <= redirect_cnt + 32'd1;
  end
`endif

  // A response with nothing outstanding means the memory broke its contract.
  a_resp_has_req: assert property (@(posedge clk) disable iff (rst)
    imem_resp_valid |-> (inflight != '0));

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: in-order memory model with variable latency, an
// architectural model of the instruction stream (sequential PCs restarting
// at each redirect/reset target) kept as an expected-PC queue, and a
// monitor that scores every instruction decode accepts.
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk, rst, br_tk_in, imem_req_valid, imem_req_ready;
  logic        imem_resp_valid, inst_valid, inst_ready;
  logic [31:0] pc_br_tk_in, imem_req_addr, imem_resp_data, inst_data, inst_pc;
`ifdef FETCH_REDIRECT_CNT_EN
  logic [31:0] redirect_cnt;
`endif

  fetch_stage #(.QUEUE_DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .br_tk_in(br_tk_in), .pc_br_tk_in(pc_br_tk_in),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
`ifdef FETCH_REDIRECT_CNT_EN
    , .redirect_cnt(redirect_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchk = 0, nerr = 0, npop = 0, nacc = 0;
  int unsigned cyc = 0, last_due = 0, lat = 1, exp_rcnt = 0;
  bit rnd_lat = 0, want_first = 0;
  logic [31:0] first_pc, exp_next, e;
  logic [31:0] exp_q[$];
  typedef struct { int unsigned due; logic [31:0] addr; } mreq_t;
  mreq_t mq[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected stream restarts at a new target; older expectations are void.
  task automatic sb_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_next = pc & ~32'd3;
    while (exp_q.size() < 8) begin exp_q.push_back(exp_next); exp_next += 4; end
  endtask

  task automatic next_cyc();
    @(posedge clk); #2;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, "_req_addr"}, imem_req_addr, RESET_PC);
    chk({tag, "_inst_valid"}, 32'(inst_valid), 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
`ifdef FETCH_REDIRECT_CNT_EN
    chk({tag, "_redirect_cnt"}, redirect_cnt, 32'd0);
`endif
  endtask

  always @(posedge clk) cyc++;

  // Memory response side: one in-order response per cycle when due.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      mq.delete();
      last_due = cyc;
      imem_resp_valid = 1'b0;
    end else if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  // Memory request side: record accepted requests with their due cycle.
  always @(negedge clk) begin
    int unsigned l, d;
    if (!rst && imem_req_valid && imem_req_ready) begin
      l = rnd_lat ? $urandom_range(1, 4) : lat;
      d = cyc + l;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{due: d, addr: imem_req_addr});
      nacc++;
    end
  end

  // Monitor: score every instruction decode accepts.
  always @(negedge clk) begin
    if (!rst) begin
      if (br_tk_in) chk("redirect_hides_head", 32'(inst_valid), 32'd0);
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL sb_empty: got pc %h expected nothing", inst_pc);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", inst_pc, e);
          chk("inst_data", inst_data, mem_word(e));
        end
        if (want_first) begin first_pc = inst_pc; want_first = 0; end
        npop++;
        while (exp_q.size() < 8) begin exp_q.push_back(exp_next); exp_next += 4; end
      end
    end
  end

  initial begin
    int p, rst_left;
    rst = 1; br_tk_in = 0; pc_br_tk_in = '0; imem_req_ready = 1; inst_ready = 1;
    imem_resp_valid = 0; imem_resp_data = '0; exp_next = RESET_PC; first_pc = '0;
    repeat (3) next_cyc();
    @(negedge clk); check_reset("rst_init");

    // Streaming with 1-cycle memory
    next_cyc(); rst = 0; sb_restart(RESET_PC);
    @(negedge clk);
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, RESET_PC);
    next_cyc(); @(negedge clk); chk("inst_valid_c1", 32'(inst_valid), 32'd0);
    next_cyc(); p = npop;
    @(negedge clk);
    chk("inst_valid_c2", 32'(inst_valid), 32'd1);
    chk("inst_pc_c2", inst_pc, RESET_PC);
    repeat (20) next_cyc();
    chk("sustained_rate", 32'(npop - p), 32'd20);

    // Mid-stream reset, then decode backpressure
    rst = 1; next_cyc(); @(negedge clk); check_reset("rst_mid");
    next_cyc(); rst = 0; inst_ready = 0; sb_restart(RESET_PC); p = nacc;
    repeat (10) next_cyc();
    chk("bp_accepted", 32'(nacc - p), 32'd4);
    @(negedge clk); chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    next_cyc(); inst_ready = 1; p = npop;
    repeat (12) next_cyc();
    chk("bp_drained", 32'(npop - p >= 4), 32'd1);

    // 3-cycle memory, redirect with three requests in flight
    rst = 1; next_cyc(); next_cyc();
    rst = 0; lat = 3; sb_restart(RESET_PC);
    repeat (3) next_cyc();
    br_tk_in = 1; pc_br_tk_in = 32'h100; sb_restart(32'h100); want_first = 1; p = npop;
    @(negedge clk); chk("rd3_inst_valid", 32'(inst_valid), 32'd0);
    next_cyc(); br_tk_in = 0;
    @(negedge clk);
    chk("rd3_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rd3_req_addr", imem_req_addr, 32'h100);
    repeat (4) next_cyc();
    chk("rd3_no_stale_pop", 32'(npop - p), 32'd0);
    repeat (4) next_cyc();
    chk("rd3_first_pc", first_pc, 32'h100);
    chk("rd3_delivered", 32'(want_first), 32'd0);

    // Redirect to unaligned target coincident with a response and valid head
    rst = 1; next_cyc(); next_cyc();
    rst = 0; lat = 1; sb_restart(RESET_PC);
    repeat (6) next_cyc();
    br_tk_in = 1; pc_br_tk_in = 32'h103; sb_restart(32'h100); want_first = 1;
    @(negedge clk); chk("rd1_inst_valid", 32'(inst_valid), 32'd0);
    next_cyc(); br_tk_in = 0;
    @(negedge clk);
    chk("rd1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rd1_req_addr", imem_req_addr, 32'h100);
    repeat (5) next_cyc();
    chk("rd1_first_pc", first_pc, 32'h100);

    // Randomized traffic: latency, readies, redirects, occasional reset
    rst = 1; next_cyc(); next_cyc();
    rst = 0; rnd_lat = 1; exp_rcnt = 0; sb_restart(RESET_PC); p = npop; rst_left = 0;
    for (int i = 0; i < 3000; i++) begin
      next_cyc();
      br_tk_in = 0;
      if (rst_left > 0) begin
        rst_left--;
        if (rst_left == 0) begin rst = 0; sb_restart(RESET_PC); end
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1; rst_left = 2; exp_rcnt = 0;
      end else if ($urandom_range(0, 24) == 0) begin
        br_tk_in = 1; pc_br_tk_in = $urandom; sb_restart(pc_br_tk_in); exp_rcnt++;
      end
      inst_ready     = ($urandom_range(0, 3) != 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
    end
    next_cyc(); br_tk_in = 0;
    if (rst) begin rst = 0; sb_restart(RESET_PC); end
    chk("rand_progress", 32'(npop - p > 200), 32'd1);
`ifdef FETCH_REDIRECT_CNT_EN
    @(negedge clk); chk("rand_redirect_cnt", redirect_cnt, exp_rcnt);
`endif

    // Five redirects, then reset clears everything
    rst = 1; next_cyc(); next_cyc();
    rst = 0; rnd_lat = 0; inst_ready = 1; imem_req_ready = 1; sb_restart(RESET_PC);
    for (int k = 0; k < 5; k++) begin
      repeat (3) next_cyc();
      br_tk_in = 1; pc_br_tk_in = 32'h400 + 32'(k * 64); sb_restart(pc_br_tk_in);
      next_cyc(); br_tk_in = 0;
    end
`ifdef FETCH_REDIRECT_CNT_EN
    @(negedge clk); chk("redirect_cnt_5", redirect_cnt, 32'd5);
`endif
    repeat (4) next_cyc();
    rst = 1; next_cyc(); @(negedge clk); check_reset("rst_final");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
